// File: rtl/lsa_pkg.sv
// Shared constants, FSM state type and position helper for the line-sensor array detector.
package lsa_pkg;

    localparam int unsigned AdcWidth = 12;
    localparam int unsigned AdcMax   = (2 ** AdcWidth) - 1;
    localparam int unsigned NumCh    = 4;

    localparam int WeightCh0 = -3;
    localparam int WeightCh1 = -1;
    localparam int WeightCh2 = 1;
    localparam int WeightCh3 = 3;

    // Each state names the channel index expected next.
    typedef enum logic [1:0] {
        StExp0 = 2'd0,
        StExp1 = 2'd1,
        StExp2 = 2'd2,
        StExp3 = 2'd3
    } lsa_state_e;

    function automatic logic [3:0] line_position(input logic [NumCh-1:0] bits);
        int sum;
        sum = 0;
        if (bits[0]) sum += WeightCh0;
        if (bits[1]) sum += WeightCh1;
        if (bits[2]) sum += WeightCh2;
        if (bits[3]) sum += WeightCh3;
        return 4'(sum);
    endfunction

endpackage

// File: rtl/lsa_hyst_cmp.sv
// One-channel hysteresis comparator: holds a line-present bit updated only when enabled.
module lsa_hyst_cmp
    import lsa_pkg::*;
#(
    parameter logic [AdcWidth-1:0] THRESH = 12'd2048,
    parameter logic [AdcWidth-1:0] HYST   = 12'd128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [AdcWidth-1:0] data,
    output logic                hit_next,
    output logic                hit
);

    localparam int unsigned HiSum = int'(THRESH) + int'(HYST);
    // Band edges clamp to the ADC code range instead of wrapping.
    localparam logic [AdcWidth-1:0] HiEdge = (HiSum > AdcMax) ? '1 : AdcWidth'(HiSum);
    localparam logic [AdcWidth-1:0] LoEdge = (HYST > THRESH) ? '0 : THRESH - HYST;

    always_comb begin
        hit_next = hit;
        if (en) begin
            if (data >= HiEdge) begin
                hit_next = 1'b1;
            end else if (data < LoEdge) begin
                hit_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit <= 1'b0;
        end else begin
            hit <= hit_next;
        end
    end

endmodule

// File: rtl/lsa_line_detect.sv
// Frames 4-channel line-sensor samples into line bits, weighted position and line-lost status.
// Define LSA_LOST_HOLD_EN to enable the lost counter and held-position behaviour.
module lsa_line_detect
    import lsa_pkg::*;
#(
    parameter logic [AdcWidth-1:0] THRESH     = 12'd2048,
    parameter logic [AdcWidth-1:0] HYST       = 12'd128,
    parameter int unsigned         LOST_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [1:0]          sample_ch,
    input  logic [AdcWidth-1:0] sample_data,
    output logic                frame_valid,
    output logic [NumCh-1:0]    line_bits,
    output logic [3:0]          position,
    output logic                line_lost,
    output logic                seq_err
);

    lsa_state_e       state_q, state_d;
    logic [1:0]       exp_ch;
    logic             accept, order_err, frame_done;
    logic [NumCh-1:0] hit_en, hit_next, hit;
    logic [3:0]       pos_cur, position_d;

    assign exp_ch = state_q;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        order_err  = 1'b0;
        frame_done = 1'b0;
        if (sample_valid) begin
            if (sample_ch == exp_ch) begin
                accept     = 1'b1;
                frame_done = (state_q == StExp3);
                state_d    = lsa_state_e'(exp_ch + 2'd1);
            end else begin
                // An out-of-order channel 0 restarts the frame rather than being dropped.
                order_err = 1'b1;
                if (sample_ch == 2'd0) begin
                    accept  = 1'b1;
                    state_d = StExp1;
                end else begin
                    state_d = StExp0;
                end
            end
        end
    end

    assign hit_en = accept ? (NumCh'(1) << sample_ch) : '0;

    for (genvar k = 0; k < NumCh; k++) begin : g_ch
        lsa_hyst_cmp #(
            .THRESH (THRESH),
            .HYST   (HYST)
        ) u_hyst (
            .clk      (clk),
            .rst      (rst),
            .en       (hit_en[k]),
            .data     (sample_data),
            .hit_next (hit_next[k]),
            .hit      (hit[k])
        );
    end

    assign pos_cur = line_position(hit_next);

`ifdef LSA_LOST_HOLD_EN
    localparam logic [7:0] LostMax = 8'(LOST_LIMIT);

    logic [7:0] lost_cnt_q, lost_cnt_d;
    logic [3:0] held_pos_q, held_pos_d;
    logic       line_lost_q, lost_d;

    always_comb begin
        lost_cnt_d = lost_cnt_q;
        held_pos_d = held_pos_q;
        if (|hit_next) begin
            lost_cnt_d = '0;
            held_pos_d = pos_cur;
        end else if (lost_cnt_q < LostMax) begin
            lost_cnt_d = lost_cnt_q + 8'd1;
        end
        lost_d     = (lost_cnt_d >= LostMax);
        position_d = lost_d ? held_pos_d : pos_cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lost_cnt_q  <= '0;
            held_pos_q  <= '0;
            line_lost_q <= 1'b0;
        end else if (frame_done) begin
            lost_cnt_q  <= lost_cnt_d;
            held_pos_q  <= held_pos_d;
            line_lost_q <= lost_d;
        end
    end

    assign line_lost = line_lost_q;
`else
    assign position_d = pos_cur;
    assign line_lost  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StExp0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            line_bits   <= '0;
            position    <= '0;
        end else begin
            state_q     <= state_d;
            frame_valid <= frame_done;
            seq_err     <= order_err;
            if (frame_done) begin
                line_bits <= hit_next;
                position  <= position_d;
            end
        end
    end

endmodule

// File: tb/tb_lsa_line_detect.sv
// Randomised + directed scoreboard bench for lsa_line_detect (honours LSA_LOST_HOLD_EN).
module tb_lsa_line_detect;

    localparam int Thresh    = 2048;
    localparam int Hyst      = 128;
    localparam int LostLimit = 8;
    localparam int HiEdge    = (Thresh + Hyst > 4095) ? 4095 : Thresh + Hyst;
    localparam int LoEdge    = (Thresh - Hyst < 0) ? 0 : Thresh - Hyst;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [11:0] sample_data;
    logic        frame_valid;
    logic [3:0]  line_bits;
    logic [3:0]  position;
    logic        line_lost;
    logic        seq_err;

    lsa_line_detect #(
        .THRESH     (12'd2048),
        .HYST       (12'd128),
        .LOST_LIMIT (LostLimit)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .frame_valid  (frame_valid),
        .line_bits    (line_bits),
        .position     (position),
        .line_lost    (line_lost),
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int bits;
        int pos;
        int lost;
    } frame_t;

    frame_t fq[$];
    int     sq[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    bit     mon_en = 1'b0;

    // Reference model state: which channel the sequence expects and the per-channel held bits.
    int     exp_ch;
    bit     hyst[4];
    int     lost_cnt;
    int     held_pos;
    int     weights[4] = '{-3, -1, 1, 3};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_ch   = 0;
        hyst     = '{0, 0, 0, 0};
        lost_cnt = 0;
        held_pos = 0;
    endtask

    task automatic model_sample(input int ch, input int data);
        bit     acc;
        frame_t f;
        acc = 1'b0;
        if (ch == exp_ch) begin
            acc = 1'b1;
        end else begin
            sq.push_back(cyc + 1);
            if (ch == 0) acc = 1'b1;
            else exp_ch = 0;
        end
        if (acc) begin
            if (data >= HiEdge) hyst[ch] = 1'b1;
            else if (data < LoEdge) hyst[ch] = 1'b0;
            if (ch == 3) begin
                f.due  = cyc + 1;
                f.bits = 0;
                f.pos  = 0;
                for (int k = 0; k < 4; k++) begin
                    if (hyst[k]) begin
                        f.bits += (1 << k);
                        f.pos  += weights[k];
                    end
                end
                f.lost = 0;
`ifdef LSA_LOST_HOLD_EN
                if (f.bits == 0) begin
                    lost_cnt = (lost_cnt < LostLimit) ? lost_cnt + 1 : LostLimit;
                end else begin
                    lost_cnt = 0;
                    held_pos = f.pos;
                end
                f.lost = (lost_cnt >= LostLimit) ? 1 : 0;
                if (f.lost != 0) f.pos = held_pos;
`endif
                fq.push_back(f);
                exp_ch = 0;
            end else begin
                exp_ch = ch + 1;
            end
        end
    endtask

    task automatic issue(input int ch, input int data);
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_ch    = 2'(ch);
        sample_data  = 12'(data);
        model_sample(ch, data);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
        end
    endtask

    task automatic frame4(input int d0, input int d1, input int d2, input int d3);
        issue(0, d0);
        issue(1, d1);
        issue(2, d2);
        issue(3, d3);
    endtask

    // Called right after idle(1) following a frame's ch3 sample: lands on its frame_valid cycle.
    task automatic expect_frame(input string name, input int bits, input int pos, input int lost);
        @(negedge clk);
        check({name, " frame_valid"}, int'(frame_valid), 1);
        check({name, " line_bits"}, int'(line_bits), bits);
        check({name, " position"}, $signed(position), pos);
        check({name, " line_lost"}, int'(line_lost), lost);
    endtask

    task automatic reset_and_check(input string name);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        sample_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check({name, " frame_valid"}, int'(frame_valid), 0);
        check({name, " seq_err"}, int'(seq_err), 0);
        check({name, " line_bits"}, int'(line_bits), 0);
        check({name, " position"}, int'(position), 0);
        check({name, " line_lost"}, int'(line_lost), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (fq.size() != 0 && fq[0].due < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing frame_valid: due cycle %0d, now %0d", fq[0].due, cyc);
                void'(fq.pop_front());
            end
            if (sq.size() != 0 && sq[0] < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing seq_err: due cycle %0d, now %0d", sq[0], cyc);
                void'(sq.pop_front());
            end
            if (frame_valid === 1'b1) begin
                if (fq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected frame_valid at cycle %0d, expected none", cyc);
                end else begin
                    frame_t f;
                    f = fq.pop_front();
                    check("sb frame cycle", cyc, f.due);
                    check("sb line_bits", int'(line_bits), f.bits);
                    check("sb position", $signed(position), f.pos);
                    check("sb line_lost", int'(line_lost), f.lost);
                end
            end
            if (seq_err === 1'b1) begin
                if (sq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected seq_err at cycle %0d, expected none", cyc);
                end else begin
                    check("sb seq_err cycle", cyc, sq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, data, mode;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_ch    = 2'd0;
        sample_data  = 12'd0;
        model_reset();
        reset_and_check("reset");
        mon_en = 1'b1;

        frame4(100, 3000, 3000, 100);
        idle(1);
        expect_frame("center", 4'b0110, 0, 0);

        frame4(3000, 3000, 100, 100);
        idle(1);
        expect_frame("left", 4'b0011, -4, 0);
        frame4(2100, 2100, 100, 100);
        idle(1);
        expect_frame("in band", 4'b0011, -4, 0);

        issue(0, 3000);
        issue(2, 3000);
        idle(3);
        frame4(100, 100, 3000, 100);
        idle(1);
        expect_frame("after seq_err", 4'b0100, 1, 0);

        // Hysteresis edges on ch0: 2176 sets, 2175/1920 hold, 1919 clears.
        frame4(2176, 100, 100, 100);
        idle(1);
        expect_frame("hi edge", 4'b0001, -3, 0);
        frame4(1920, 100, 100, 100);
        idle(1);
        expect_frame("lo edge hold", 4'b0001, -3, 0);
        frame4(1919, 100, 100, 100);
        idle(1);
        frame4(2175, 100, 100, 100);
        idle(1);
        expect_frame("below hi edge", 4'b0000, 0, 0);

        frame4(100, 100, 3000, 3000);
        for (int i = 0; i < LostLimit; i++) frame4(100, 100, 100, 100);
        idle(1);
`ifdef LSA_LOST_HOLD_EN
        expect_frame("lost", 4'b0000, 4, 1);
`else
        expect_frame("lost", 4'b0000, 0, 0);
`endif
        frame4(3000, 100, 100, 100);
        idle(1);
        expect_frame("recovered", 4'b0001, -3, 0);

        issue(0, 3000);
        issue(1, 3000);
        reset_and_check("mid-frame reset");
        frame4(100, 3000, 3000, 100);
        idle(1);
        expect_frame("post reset", 4'b0110, 0, 0);

        for (int i = 0; i < 480; i++) begin
            mode = (i / 40) % 3;
            if ($urandom_range(0, 9) < 2) idle($urandom_range(1, 2));
            ch = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : exp_ch;
            if (mode == 2) data = $urandom_range(0, LoEdge - 1);
            else if (mode == 1) data = $urandom_range(LoEdge - 8, HiEdge + 8);
            else data = $urandom_range(0, 4095);
            issue(ch, data);
        end
        idle(4);
        check("frames drained", fq.size(), 0);
        check("seq_err drained", sq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsa_line_detect.md
LSA_LINE_DETECT -- requirements
Module: lsa_line_detect

Interface
REQ-001 Parameter THRESH, 12'd2048, nominal black/white threshold on raw ADC code.
REQ-002 Parameter HYST, 12'd128, half-width of hysteresis band around THRESH.
REQ-003 Parameter LOST_LIMIT, 8, consecutive empty frames before line_lost asserts (range 1..255).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sample_valid  in  1  one-cycle strobe; sample_ch/sample_data valid this cycle.
REQ-007 sample_ch  in  2  channel index 0..3 of the upstream 4-channel ADC reader.
REQ-008 sample_data  in  12  converted ADC code, unsigned.
REQ-009 frame_valid  out  1  one-cycle pulse; line_bits/position/line_lost updated.
REQ-010 line_bits  out  4  per-channel line-present bits, bit k = channel k.
REQ-011 position  out  4  signed weighted line position, range -4..+4.
REQ-012 line_lost  out  1  level; line absent for LOST_LIMIT frames.
REQ-013 seq_err  out  1  one-cycle pulse on out-of-order sample.

Function
REQ-014 FSM states EXP0, EXP1, EXP2, EXP3; state EXPk accepts only sample_ch==k with sample_valid.
REQ-015 Accepted sample in EXPk advances to EXP(k+1); accepted sample in EXP3 returns to EXP0 and completes a frame.
REQ-016 sample_valid with wrong channel: seq_err pulses next cycle, partial frame discarded; if sample_ch==0 it is accepted as channel 0 and FSM goes to EXP1, else FSM goes to EXP0.
REQ-017 sample_valid low: FSM holds state indefinitely; no timeout.
REQ-018 Per-channel hysteresis bit: set when data >= THRESH+HYST, cleared when data < THRESH-HYST, else held; band edges saturate at 0 and 4095.
REQ-019 Hysteresis bits update at each accepted sample, including samples of a later-discarded frame.
REQ-020 frame_valid pulses exactly one cycle after the EXP3 sample is accepted; line_bits, position, line_lost registered in that same cycle and held until the next frame.
REQ-021 position = sum of weights of set line_bits, weights ch0..ch3 = -3, -1, +1, +3; all-clear gives 0.
REQ-022 Empty frame (line_bits==0) increments lost counter, saturating at LOST_LIMIT; non-empty frame clears it.
REQ-023 Back-to-back samples on consecutive cycles supported with no stall; throughput one sample per cycle.

Reset
REQ-024 On rst: FSM to EXP0, hysteresis bits 0, lost counter 0, held position 0, all outputs 0.
REQ-025 rst mid-frame discards the partial frame without a seq_err or frame_valid pulse.

Configuration
REQ-026 Macro LSA_LOST_HOLD_EN defined: line_lost asserts when lost counter reaches LOST_LIMIT; while line_lost, position outputs the last non-empty-frame position.
REQ-027 Macro LSA_LOST_HOLD_EN undefined: lost counter and held position absent, line_lost tied 0, position always reflects current frame.

Structure
REQ-028 Package lsa_pkg holds ADC width (12), channel count (4), channel weight constants, and the FSM state enum.
REQ-029 Sub-module lsa_hyst_cmp (one channel: data, enable, THRESH, HYST -> held bit) instantiated four times.

Verification
REQ-030 Samples ch0..3 = 100, 3000, 3000, 100 consecutive cycles -> frame_valid 1 cycle after ch3; line_bits=4'b0110, position=0.
REQ-031 Frame 3000,3000,100,100 -> line_bits=4'b0011, position=-4; then frame 2100,2100,100,100 -> line_bits unchanged (inside band).
REQ-032 Sequence ch0, ch2 -> seq_err pulse, no frame_valid; following ch0..3 frame completes normally.
REQ-033 LSA_LOST_HOLD_EN, LOST_LIMIT=8: frame 100,100,3000,3000 (position=+4) then 8 all-100 frames -> line_lost rises on 8th frame_valid, position holds +4; next non-empty frame clears line_lost.
REQ-034 rst asserted after ch1 accepted -> outputs 0, no pulses; fresh ch0..3 frame yields frame_valid normally.
